// File: rtl/elevador_cabina.sv
// Car-side model of the elevator: follows up/down motor commands across three
// floors, holds the door open on arrival and latches a fault on illegal commands.
module elevador_cabina #(
  parameter int TICKS_PER_FLOOR = 8,
  parameter int DOOR_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       motorsubir,
  input  logic       motorbajar,
  output logic [3:0] piso,
  output logic       llegada,
  output logic       en_movimiento,
  output logic       puerta_abierta,
  output logic       falla
);

  localparam int TW = (TICKS_PER_FLOOR > 1) ? $clog2(TICKS_PER_FLOOR) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_FLOOR - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    REPOSO,
    SUBIENDO,
    BAJANDO,
    PUERTA,
    FALLA
  } estado_t;

  estado_t       state_q, state_d;
  logic [3:0]    piso_q, piso_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] door_q, door_d;
  logic          llegada_q, llegada_d;
  logic          en_mov_q, en_mov_d;
  logic          puerta_q, puerta_d;
  logic          falla_q, falla_d;

  logic cmd_up, cmd_down, cmd_both;

  assign cmd_up   = motorsubir & ~motorbajar;
  assign cmd_down = motorbajar & ~motorsubir;
  assign cmd_both = motorsubir & motorbajar;

  always_comb begin
    state_d   = state_q;
    piso_d    = piso_q;
    tick_d    = tick_q;
    door_d    = door_q;
    llegada_d = 1'b0;

    if (state_q != FALLA && cmd_both) begin
      state_d = FALLA;
    end else begin
      case (state_q)
        REPOSO: begin
          // Up at the top floor or down at the bottom is a quiet limit stop.
          if (cmd_up && piso_q < 4'd3) begin
            state_d = SUBIENDO;
            tick_d  = '0;
          end else if (cmd_down && piso_q > 4'd1) begin
            state_d = BAJANDO;
            tick_d  = '0;
          end
        end
        SUBIENDO: begin
          if (cmd_down) begin
            state_d = FALLA;
          end else if (cmd_up) begin
            if (tick_q == TICK_LAST) begin
              piso_d    = piso_q + 4'd1;
              llegada_d = 1'b1;
              tick_d    = '0;
              door_d    = '0;
              state_d   = PUERTA;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        BAJANDO: begin
          if (cmd_up) begin
            state_d = FALLA;
          end else if (cmd_down) begin
            if (tick_q == TICK_LAST) begin
              piso_d    = piso_q - 4'd1;
              llegada_d = 1'b1;
              tick_d    = '0;
              door_d    = '0;
              state_d   = PUERTA;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        PUERTA: begin
          // Door interlock: motor commands are ignored until the door closes.
          if (door_q == DOOR_LAST) begin
            door_d  = '0;
            state_d = REPOSO;
          end else begin
            door_d = door_q + 1'b1;
          end
        end
        FALLA: begin
          state_d = FALLA;
        end
        default: begin
          state_d = FALLA;
        end
      endcase
    end

    en_mov_d = (state_d == SUBIENDO) || (state_d == BAJANDO);
    puerta_d = (state_d == PUERTA);
    falla_d  = (state_d == FALLA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REPOSO;
      piso_q    <= 4'd1;
      tick_q    <= '0;
      door_q    <= '0;
      llegada_q <= 1'b0;
      en_mov_q  <= 1'b0;
      puerta_q  <= 1'b0;
      falla_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      piso_q    <= piso_d;
      tick_q    <= tick_d;
      door_q    <= door_d;
      llegada_q <= llegada_d;
      en_mov_q  <= en_mov_d;
      puerta_q  <= puerta_d;
      falla_q   <= falla_d;
    end
  end

  assign piso           = piso_q;
  assign llegada        = llegada_q;
  assign en_movimiento  = en_mov_q;
  assign puerta_abierta = puerta_q;
  assign falla          = falla_q;

endmodule

// File: tb/tb_elevador_cabina.sv
// Bench for elevador_cabina: a fixed vector table, directed corner sequences and
// random commands checked against a remaining-ticks/door-countdown car model.
module tb_elevador_cabina;

  localparam int TICKS = 8;
  localparam int DOOR  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       motorsubir;
  logic       motorbajar;
  logic [3:0] piso;
  logic       llegada;
  logic       en_movimiento;
  logic       puerta_abierta;
  logic       falla;

  int checks = 0;
  int errors = 0;

  elevador_cabina #(.TICKS_PER_FLOOR(TICKS), .DOOR_CYCLES(DOOR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .motorsubir     (motorsubir),
    .motorbajar     (motorbajar),
    .piso           (piso),
    .llegada        (llegada),
    .en_movimiento  (en_movimiento),
    .puerta_abierta (puerta_abierta),
    .falla          (falla)
  );

  always #5 clk = ~clk;

  // Car model: floor as an integer, travel as ticks still to go, door as cycles left.
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3, M_FAULT = 4;
  int m_floor, m_mode, m_remaining, m_door_left;
  bit m_arrive;

  function automatic void model_reset();
    m_floor = 1; m_mode = M_IDLE; m_remaining = 0; m_door_left = 0; m_arrive = 0;
  endfunction

  function automatic void model_step(bit up, bit dn);
    m_arrive = 0;
    if (m_mode != M_FAULT && up && dn) begin
      m_mode = M_FAULT;
    end else if (m_mode == M_IDLE) begin
      if (up && !dn && m_floor < 3) begin m_mode = M_UP; m_remaining = TICKS; end
      else if (dn && !up && m_floor > 1) begin m_mode = M_DOWN; m_remaining = TICKS; end
    end else if (m_mode == M_UP || m_mode == M_DOWN) begin
      bit fwd, rev;
      fwd = (m_mode == M_UP) ? (up && !dn) : (dn && !up);
      rev = (m_mode == M_UP) ? (dn && !up) : (up && !dn);
      if (rev) m_mode = M_FAULT;
      else if (fwd) begin
        m_remaining = m_remaining - 1;
        if (m_remaining == 0) begin
          m_floor     = m_floor + ((m_mode == M_UP) ? 1 : -1);
          m_arrive    = 1;
          m_mode      = M_DOOR;
          m_door_left = DOOR;
        end
      end
    end else if (m_mode == M_DOOR) begin
      m_door_left = m_door_left - 1;
      if (m_door_left == 0) m_mode = M_IDLE;
    end
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, " piso"}, int'(piso), m_floor);
    chk({tag, " llegada"}, int'(llegada), int'(m_arrive));
    chk({tag, " en_movimiento"}, int'(en_movimiento), int'(m_mode == M_UP || m_mode == M_DOWN));
    chk({tag, " puerta_abierta"}, int'(puerta_abierta), int'(m_mode == M_DOOR));
    chk({tag, " falla"}, int'(falla), int'(m_mode == M_FAULT));
  endtask

  // Called just after a falling edge: drops rst_n between edges and checks
  // the outputs change without waiting for a clock.
  task automatic do_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, " rst piso"}, int'(piso), 1);
    chk({tag, " rst llegada"}, int'(llegada), 0);
    chk({tag, " rst en_movimiento"}, int'(en_movimiento), 0);
    chk({tag, " rst puerta_abierta"}, int'(puerta_abierta), 0);
    chk({tag, " rst falla"}, int'(falla), 0);
    model_reset();
    motorsubir = 1'b0;
    motorbajar = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(bit up, bit dn, string tag);
    motorsubir = up;
    motorbajar = dn;
    @(posedge clk);
    model_step(up, dn);
    @(negedge clk);
    chk_model(tag);
  endtask

  // Holds a command until llegada is seen; edges counts the sampling edge as 1.
  task automatic travel(bit up, bit dn, string tag, output int edges);
    edges = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(up, dn, tag);
      edges++;
      if (llegada) break;
    end
    if (!llegada) chk({tag, " arrival timeout"}, 0, 1);
  endtask

  typedef struct {
    bit rst_n; bit up; bit dn;
    int piso; bit ll; bit mov; bit pu; bit f;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, bit u, bit d, int p, bit l, bit m, bit pu, bit f);
    vec_t v;
    v.rst_n = r; v.up = u; v.dn = d; v.piso = p; v.ll = l; v.mov = m; v.pu = pu; v.f = f;
    tbl.push_back(v);
  endfunction

  initial begin
    int n, a, b;
    rst_n = 1'b0; motorsubir = 1'b0; motorbajar = 1'b0;
    model_reset();

    // Reset, then hold up: travel, arrival, door, re-departure, then BOTH.
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 1, 0, 1, 0, 1, 0, 0);
    add(1, 1, 0, 2, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 2, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 0, 0, 0);
    add(1, 1, 0, 2, 0, 1, 0, 0);
    add(1, 0, 0, 2, 0, 1, 0, 0);
    add(1, 1, 1, 2, 0, 0, 0, 1);
    add(1, 0, 1, 2, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; motorsubir = tbl[i].up; motorbajar = tbl[i].dn;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d piso", i), int'(piso), tbl[i].piso);
      chk($sformatf("vec%0d llegada", i), int'(llegada), int'(tbl[i].ll));
      chk($sformatf("vec%0d en_movimiento", i), int'(en_movimiento), int'(tbl[i].mov));
      chk($sformatf("vec%0d puerta_abierta", i), int'(puerta_abierta), int'(tbl[i].pu));
      chk($sformatf("vec%0d falla", i), int'(falla), int'(tbl[i].f));
    end

    // Floor 2 -> 3, up held through the door and beyond, then down to 2.
    do_reset("s2");
    travel(1, 0, "s2 up1", n); chk("s2 edges 1to2", n, 9);
    for (int i = 0; i < DOOR; i++) cycle(0, 0, "s2 door");
    travel(1, 0, "s2 up2", n); chk("s2 edges 2to3", n, 9);
    for (int i = 0; i < 10; i++) cycle(1, 0, "s2 limit");
    chk("s2 piso at top", int'(piso), 3);
    chk("s2 falla at top", int'(falla), 0);
    travel(0, 1, "s2 down", n); chk("s2 edges 3to2", n, 9);
    chk("s2 piso after down", int'(piso), 2);

    // Down at floor 1 is ignored; a 3-cycle pause delays arrival by 3.
    do_reset("s3");
    for (int i = 0; i < 20; i++) cycle(0, 1, "s3 floor1 down");
    chk("s3 piso", int'(piso), 1);
    chk("s3 en_movimiento", int'(en_movimiento), 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, "s3 go");
    for (int i = 0; i < 3; i++) cycle(0, 0, "s3 pause");
    travel(1, 0, "s3 resume", n);
    chk("s3 paused arrival edges", 7 + n, 12);

    // Reversal after 3 ticks, then sticky fault.
    do_reset("s4");
    for (int i = 0; i < 4; i++) cycle(1, 0, "s4 go");
    cycle(0, 1, "s4 reverse");
    chk("s4 falla", int'(falla), 1);
    chk("s4 en_movimiento", int'(en_movimiento), 0);
    chk("s4 piso", int'(piso), 1);
    for (int i = 0; i < 6; i++) cycle(i[0], ~i[0], "s4 stuck");
    chk("s4 falla sticky", int'(falla), 1);

    // BOTH in REPOSO, and BOTH during the door.
    do_reset("s5a");
    cycle(1, 1, "s5a both");
    chk("s5a falla", int'(falla), 1);
    do_reset("s5b");
    travel(1, 0, "s5b up", n);
    cycle(0, 0, "s5b door");
    cycle(1, 1, "s5b both");
    chk("s5b falla", int'(falla), 1);
    chk("s5b puerta_abierta", int'(puerta_abierta), 0);

    // Asynchronous reset at tick 5, then a full fresh trip.
    do_reset("s6");
    for (int i = 0; i < 6; i++) cycle(1, 0, "s6 go");
    do_reset("s6 mid");
    travel(1, 0, "s6 fresh", n);
    chk("s6 fresh edges", n, 9);

    // Random commands against the model.
    do_reset("rnd");
    for (int i = 0; i < 3000; i++) begin
      a = $urandom_range(0, 199);
      b = $urandom_range(0, 499);
      if ((m_mode == M_FAULT && $urandom_range(0, 7) == 0) || b == 0) do_reset("rnd");
      if (a == 0) cycle(1, 1, "rnd");
      else if (a < 90) cycle(1, 0, "rnd");
      else if (a < 170) cycle(0, 1, "rnd");
      else cycle(0, 0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
